// File: rtl/video_timing_analyzer.sv
// rtl/video_timing_analyzer.sv - measures incoming video line/frame timing, lock state
// and the position of the first bright active pixel in each frame.
module video_timing_analyzer #(
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter logic [3:0]  STABLE_FRAMES   = 4'd3,
  parameter logic [7:0]  LUMA_THRESH     = 8'h80,
  parameter logic [10:0] V_TIMEOUT       = 11'd1023
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        HSYNC_in,
  input  logic        VSYNC_in,
  input  logic        ENABLE_in,
  input  logic [7:0]  G_in,
  output logic [11:0] h_total,
  output logic [11:0] h_synclen,
  output logic [11:0] h_active,
  output logic [10:0] v_total,
  output logic [10:0] v_synclen,
  output logic [10:0] v_active,
  output logic        locked,
  output logic        frame_strobe,
  output logic        lt_found,
  output logic [11:0] lt_x,
  output logic [10:0] lt_y
);

  typedef struct packed {
    logic [11:0] ht;
    logic [11:0] hs;
    logic [11:0] ha;
    logic [10:0] vt;
    logic [10:0] vs;
    logic [10:0] va;
  } meas_t;

  logic        hs_s_q, vs_s_q, de_s_q, hs_p_q, vs_p_q;
  logic [7:0]  g_s_q;
  logic        hs_lead, hs_trail, vs_lead, vs_trail, de_nz, timeout;

  logic [11:0] pix_q, pix_d, pix_inc, de_cnt_q, de_cnt_d;
  logic [11:0] line_tot_q, line_tot_d, line_act_q, line_act_d, line_sync_q, line_sync_d;
  logic [10:0] line_cnt_q, line_cnt_d, line_inc, vsync_len_q, vsync_len_d;
  logic [10:0] act_lines_q, act_lines_d, act_inc;
  logic        found_q, found_d;
  logic [11:0] box_x_q, box_x_d;
  logic [10:0] box_y_q, box_y_d;

  meas_t       cur, prev_q, prev_d, pub_q, pub_d;
  logic [3:0]  stable_q, stable_d, stable_nxt;
  logic        locked_q, locked_d, pend_q, pend_d, strobe_q, strobe_d;
  logic        lt_found_q, lt_found_d;
  logic [11:0] lt_x_q, lt_x_d;
  logic [10:0] lt_y_q, lt_y_d;

  assign hs_lead  = SYNC_ACTIVE_LOW ? (hs_p_q & ~hs_s_q) : (~hs_p_q & hs_s_q);
  assign hs_trail = SYNC_ACTIVE_LOW ? (~hs_p_q & hs_s_q) : (hs_p_q & ~hs_s_q);
  assign vs_lead  = SYNC_ACTIVE_LOW ? (vs_p_q & ~vs_s_q) : (~vs_p_q & vs_s_q);
  assign vs_trail = SYNC_ACTIVE_LOW ? (~vs_p_q & vs_s_q) : (vs_p_q & ~vs_s_q);

  always_comb begin
    pix_inc  = (pix_q == 12'hFFF) ? pix_q : pix_q + 12'd1;
    line_inc = (line_cnt_q == 11'h7FF) ? line_cnt_q : line_cnt_q + 11'd1;
    act_inc  = (act_lines_q == 11'h7FF) ? act_lines_q : act_lines_q + 11'd1;
    de_nz    = (de_cnt_q != 12'd0);
    timeout  = (pix_q == 12'hFFF) || (line_cnt_q >= V_TIMEOUT);

    pix_d = hs_lead ? 12'd0 : pix_inc;
    // The in-progress line belongs to the frame being closed, so vs_lead also restarts it.
    de_cnt_d = de_cnt_q;
    if (hs_lead || vs_lead)
      de_cnt_d = 12'd0;
    else if (de_s_q && (de_cnt_q != 12'hFFF))
      de_cnt_d = de_cnt_q + 12'd1;

    line_tot_d  = hs_lead ? pix_inc : line_tot_q;
    line_act_d  = (hs_lead && de_nz) ? de_cnt_q : line_act_q;
    line_sync_d = hs_trail ? pix_inc : line_sync_q;

    line_cnt_d = line_cnt_q;
    if (vs_lead)
      line_cnt_d = {10'd0, hs_lead};
    else if (hs_lead)
      line_cnt_d = line_inc;
    vsync_len_d = vs_trail ? line_cnt_q : vsync_len_q;
    act_lines_d = act_lines_q;
    if (vs_lead)
      act_lines_d = 11'd0;
    else if (hs_lead && de_nz)
      act_lines_d = act_inc;

    found_d = found_q;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    if (vs_lead) begin
      found_d = 1'b0;
    end else if (!found_q && de_s_q && (g_s_q >= LUMA_THRESH)) begin
      found_d = 1'b1;
      box_x_d = de_cnt_q;
      box_y_d = act_lines_q;
    end

    // h_active comes from the last line that carried data; blanking lines leave it alone.
    cur.ht = hs_lead ? pix_inc : line_tot_q;
    cur.hs = line_sync_q;
    cur.ha = de_nz ? de_cnt_q : line_act_q;
    cur.vt = line_cnt_q;
    cur.vs = vsync_len_q;
    cur.va = de_nz ? act_inc : act_lines_q;

    stable_nxt = 4'd0;
    if (!pend_q && (cur == prev_q))
      stable_nxt = (stable_q >= STABLE_FRAMES) ? STABLE_FRAMES : stable_q + 4'd1;

    pub_d      = pub_q;
    prev_d     = prev_q;
    stable_d   = stable_q;
    locked_d   = locked_q;
    pend_d     = pend_q;
    lt_found_d = lt_found_q;
    lt_x_d     = lt_x_q;
    lt_y_d     = lt_y_q;
    if (vs_lead) begin
      pub_d      = cur;
      prev_d     = cur;
      stable_d   = stable_nxt;
      locked_d   = (stable_nxt == STABLE_FRAMES);
      pend_d     = 1'b0;
      lt_found_d = found_q;
      lt_x_d     = found_q ? box_x_q : 12'd0;
      lt_y_d     = found_q ? box_y_q : 11'd0;
    end
    // pend forces the next frame to count as a mismatch after reset or a timeout.
    if (timeout) begin
      stable_d = 4'd0;
      locked_d = 1'b0;
      pend_d   = 1'b1;
    end
    strobe_d = vs_lead;
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      hs_s_q      <= 1'b0;
      vs_s_q      <= 1'b0;
      de_s_q      <= 1'b0;
      g_s_q       <= 8'd0;
      hs_p_q      <= 1'b0;
      vs_p_q      <= 1'b0;
      pix_q       <= 12'd0;
      de_cnt_q    <= 12'd0;
      line_tot_q  <= 12'd0;
      line_act_q  <= 12'd0;
      line_sync_q <= 12'd0;
      line_cnt_q  <= 11'd0;
      vsync_len_q <= 11'd0;
      act_lines_q <= 11'd0;
      found_q     <= 1'b0;
      box_x_q     <= 12'd0;
      box_y_q     <= 11'd0;
      prev_q      <= '0;
      pub_q       <= '0;
      stable_q    <= 4'd0;
      locked_q    <= 1'b0;
      pend_q      <= 1'b1;
      strobe_q    <= 1'b0;
      lt_found_q  <= 1'b0;
      lt_x_q      <= 12'd0;
      lt_y_q      <= 11'd0;
    end else begin
      hs_s_q      <= HSYNC_in;
      vs_s_q      <= VSYNC_in;
      de_s_q      <= ENABLE_in;
      g_s_q       <= G_in;
      hs_p_q      <= hs_s_q;
      vs_p_q      <= vs_s_q;
      pix_q       <= pix_d;
      de_cnt_q    <= de_cnt_d;
      line_tot_q  <= line_tot_d;
      line_act_q  <= line_act_d;
      line_sync_q <= line_sync_d;
      line_cnt_q  <= line_cnt_d;
      vsync_len_q <= vsync_len_d;
      act_lines_q <= act_lines_d;
      found_q     <= found_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      prev_q      <= prev_d;
      pub_q       <= pub_d;
      stable_q    <= stable_d;
      locked_q    <= locked_d;
      pend_q      <= pend_d;
      strobe_q    <= strobe_d;
      lt_found_q  <= lt_found_d;
      lt_x_q      <= lt_x_d;
      lt_y_q      <= lt_y_d;
    end
  end

  assign h_total      = pub_q.ht;
  assign h_synclen    = pub_q.hs;
  assign h_active     = pub_q.ha;
  assign v_total      = pub_q.vt;
  assign v_synclen    = pub_q.vs;
  assign v_active     = pub_q.va;
  assign locked       = locked_q;
  assign frame_strobe = strobe_q;
  assign lt_found     = lt_found_q;
  assign lt_x         = lt_x_q;
  assign lt_y         = lt_y_q;

endmodule

// File: tb/tb_video_timing_analyzer.sv
// tb/tb_video_timing_analyzer.sv - directed frame-table bench for video_timing_analyzer,
// driving an active-low-sync instance and an active-high-sync instance from one stream.
`timescale 1ns/1ps
module tb_video_timing_analyzer;

  // Reduced raster so the run stays short: 100 (or 101) x 22, DE 64x18 at (20,3).
  localparam int HSW = 10, HDE0 = 20, HDEW = 64;
  localparam int VT = 22, VSW = 2, VDE0 = 3, VDEL = 18;
  localparam int BX = 40, BY = 16;

  logic        clk27, reset_n, hs_act, vs_act, de;
  logic [7:0]  g;
  logic        hs_n, vs_n;
  logic [11:0] h_total [2];
  logic [11:0] h_synclen [2];
  logic [11:0] h_active [2];
  logic [11:0] lt_x [2];
  logic [10:0] v_total [2];
  logic [10:0] v_synclen [2];
  logic [10:0] v_active [2];
  logic [10:0] lt_y [2];
  logic        locked [2];
  logic        frame_strobe [2];
  logic        lt_found [2];

  assign hs_n = ~hs_act;
  assign vs_n = ~vs_act;

  video_timing_analyzer #(.SYNC_ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk27(clk27), .reset_n(reset_n), .HSYNC_in(hs_n), .VSYNC_in(vs_n),
    .ENABLE_in(de), .G_in(g),
    .h_total(h_total[0]), .h_synclen(h_synclen[0]), .h_active(h_active[0]),
    .v_total(v_total[0]), .v_synclen(v_synclen[0]), .v_active(v_active[0]),
    .locked(locked[0]), .frame_strobe(frame_strobe[0]), .lt_found(lt_found[0]),
    .lt_x(lt_x[0]), .lt_y(lt_y[0])
  );

  video_timing_analyzer #(.SYNC_ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk27(clk27), .reset_n(reset_n), .HSYNC_in(hs_act), .VSYNC_in(vs_act),
    .ENABLE_in(de), .G_in(g),
    .h_total(h_total[1]), .h_synclen(h_synclen[1]), .h_active(h_active[1]),
    .v_total(v_total[1]), .v_synclen(v_synclen[1]), .v_active(v_active[1]),
    .locked(locked[1]), .frame_strobe(frame_strobe[1]), .lt_found(lt_found[1]),
    .lt_x(lt_x[1]), .lt_y(lt_y[1])
  );

  typedef struct { int ht, hs, ha, vt, vs, va, lk, fd, lx, ly; } snap_t;
  typedef struct {
    int ht, box;
    int e_ht, e_hs, e_ha, e_vt, e_vs, e_va, e_lk, e_fd, e_lx, e_ly;
  } vec_t;

  vec_t  vecs [10];
  snap_t q_lo [$];
  snap_t q_hi [$];
  int    n_cmp, n_bad;

  initial begin
    clk27 = 1'b0;
    forever #5 clk27 = ~clk27;
  end

  function automatic snap_t take(input int d);
    snap_t s;
    s.ht = int'(h_total[d]);   s.hs = int'(h_synclen[d]); s.ha = int'(h_active[d]);
    s.vt = int'(v_total[d]);   s.vs = int'(v_synclen[d]); s.va = int'(v_active[d]);
    s.lk = int'(locked[d]);    s.fd = int'(lt_found[d]);
    s.lx = int'(lt_x[d]);      s.ly = int'(lt_y[d]);
    return s;
  endfunction

  always @(negedge clk27) begin
    if (frame_strobe[0] === 1'b1) q_lo.push_back(take(0));
    if (frame_strobe[1] === 1'b1) q_hi.push_back(take(1));
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_vec(input string tag, input snap_t s, input vec_t v);
    check({tag, " h_total"},   s.ht, v.e_ht);
    check({tag, " h_synclen"}, s.hs, v.e_hs);
    check({tag, " h_active"},  s.ha, v.e_ha);
    check({tag, " v_total"},   s.vt, v.e_vt);
    check({tag, " v_synclen"}, s.vs, v.e_vs);
    check({tag, " v_active"},  s.va, v.e_va);
    check({tag, " locked"},    s.lk, v.e_lk);
    check({tag, " lt_found"},  s.fd, v.e_fd);
    check({tag, " lt_x"},      s.lx, v.e_lx);
    check({tag, " lt_y"},      s.ly, v.e_ly);
  endtask

  task automatic check_zero(input string tag);
    vec_t z;
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int d = 0; d < 2; d++) begin
      cmp_vec($sformatf("%s dut%0d", tag, d), take(d), z);
      check($sformatf("%s dut%0d frame_strobe", tag, d), int'(frame_strobe[d]), 0);
    end
  endtask

  // Drives lines y_from..y_to-1 of a frame; a bright 8x8 box sits at active (BX,BY).
  task automatic run_lines(input int ht, input int box, input int y_from, input int y_to,
                           input int rst_line);
    for (int y = y_from; y < y_to; y++) begin
      for (int x = 0; x < ht; x++) begin
        @(negedge clk27);
        hs_act = (x < HSW);
        vs_act = (y < VSW);
        de     = (x >= HDE0) && (x < HDE0 + HDEW) && (y >= VDE0) && (y < VDE0 + VDEL);
        g      = (box != 0 && de && (x - HDE0 >= BX) && (x - HDE0 < BX + 8) &&
                  (y - VDE0 >= BY) && (y - VDE0 < BY + 8)) ? 8'hFF : 8'h50;
        if (y == rst_line && x == 50) begin
          reset_n = 1'b0;
          #1;
          check_zero("midframe_reset");
        end
        if (y == rst_line && x == 60) reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    snap_t s;
    n_cmp = 0;
    n_bad = 0;
    //            ht  box  h_tot hsy hact v_tot vsy vact lock fnd  x   y
    vecs[0] = '{100, 1,   100, 10, 64,  22,   2,  18,  0,   1,  40, 16};
    vecs[1] = '{100, 1,   100, 10, 64,  22,   2,  18,  0,   1,  40, 16};
    vecs[2] = '{100, 1,   100, 10, 64,  22,   2,  18,  0,   1,  40, 16};
    vecs[3] = '{100, 1,   100, 10, 64,  22,   2,  18,  1,   1,  40, 16};
    vecs[4] = '{100, 0,   100, 10, 64,  22,   2,  18,  1,   0,   0,  0};
    vecs[5] = '{101, 1,   101, 10, 64,  22,   2,  18,  0,   1,  40, 16};
    vecs[6] = '{100, 1,   100, 10, 64,  22,   2,  18,  0,   1,  40, 16};
    vecs[7] = '{100, 1,   100, 10, 64,  22,   2,  18,  0,   1,  40, 16};
    vecs[8] = '{100, 1,   100, 10, 64,  22,   2,  18,  0,   1,  40, 16};
    vecs[9] = '{100, 1,   100, 10, 64,  22,   2,  18,  1,   1,  40, 16};

    reset_n = 1'b0;
    hs_act  = 1'b0;
    vs_act  = 1'b0;
    de      = 1'b0;
    g       = 8'd0;
    repeat (5) @(negedge clk27);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (20) @(negedge clk27);

    // Strobe 0 closes the pre-stream partial frame; strobe k closes vector k-1.
    for (int i = 0; i < 10; i++) run_lines(vecs[i].ht, vecs[i].box, 0, VT, -1);
    run_lines(100, 1, 0, 10, -1);
    check("dut0 strobe count", q_lo.size(), 11);
    check("dut1 strobe count", q_hi.size(), 11);
    for (int k = 1; k < 11; k++) begin
      if (k < q_lo.size()) cmp_vec($sformatf("dut0 frame%0d", k - 1), q_lo[k], vecs[k - 1]);
      if (k < q_hi.size()) cmp_vec($sformatf("dut1 frame%0d", k - 1), q_hi[k], vecs[k - 1]);
    end
    check("dut0 locked before reset", int'(locked[0]), 1);
    check("dut1 locked before reset", int'(locked[1]), 1);
    q_lo.delete();
    q_hi.delete();

    // Reset mid-frame, finish the partial frame, then four full frames to re-lock.
    run_lines(100, 1, 10, VT, 10);
    for (int i = 0; i < 4; i++) run_lines(100, 1, 0, VT, -1);
    run_lines(100, 1, 0, VSW, -1);
    @(negedge clk27);
    hs_act = 1'b0;
    vs_act = 1'b0;
    de     = 1'b0;
    g      = 8'd0;
    check("dut0 strobes after reset", q_lo.size(), 5);
    check("dut1 strobes after reset", q_hi.size(), 5);
    for (int d = 0; d < 2; d++) begin
      if ((d == 0 ? q_lo.size() : q_hi.size()) > 0) begin
        s = (d == 0) ? q_lo[0] : q_hi[0];
        check($sformatf("dut%0d partial frame locked", d), s.lk, 0);
      end
      for (int k = 1; k < 5; k++) begin
        if (k < (d == 0 ? q_lo.size() : q_hi.size())) begin
          s = (d == 0) ? q_lo[k] : q_hi[k];
          cmp_vec($sformatf("dut%0d relock%0d", d, k - 1), s, vecs[k - 1]);
        end
      end
      check($sformatf("dut%0d locked before timeout", d), int'(locked[d]), 1);
    end

    // Syncs stop: lock must drop once pix_cnt saturates; published timing holds.
    repeat (4200) @(negedge clk27);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d locked after timeout", d), int'(locked[d]), 0);
      check($sformatf("dut%0d h_total held", d), int'(h_total[d]), 100);
      check($sformatf("dut%0d v_total held", d), int'(v_total[d]), 22);
    end
    check("dut0 no strobe while stalled", q_lo.size(), 5);
    check("dut1 no strobe while stalled", q_hi.size(), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
